// File: rtl/hyperbus_cs_ctrl.sv
// rtl/hyperbus_cs_ctrl.sv - HyperBus chip-select and tCSS/tCSH/tRWR/tCSM timing controller
module hyperbus_cs_ctrl #(
    parameter int unsigned NR_CS        = 2,
    parameter int unsigned T_CSS        = 1,
    parameter int unsigned T_CSH        = 1,
    parameter int unsigned T_RWR        = 6,
    parameter int unsigned T_CSM_CYCLES = 400,
    parameter int unsigned T_CSM_MARGIN = 32,
    parameter int unsigned CNT_WIDTH    = 10
) (
    input  logic             clk270,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic [NR_CS-1:0] cs_sel_i,
    output logic             ready_o,
    output logic             ck_en_o,
    output logic [NR_CS-1:0] hyper_cs_no,
    output logic             tcsm_warn_o,
    output logic             tcsm_viol_o,
    output logic             sel_err_o,
    input  logic             err_clr_i
);

    localparam int unsigned PH_MAX0 = (T_CSS > T_CSH) ? T_CSS : T_CSH;
    localparam int unsigned PH_MAX  = (PH_MAX0 > T_RWR) ? PH_MAX0 : T_RWR;
    localparam int unsigned PH_W    = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0] CSS_END = PH_W'(T_CSS - 1);
    localparam logic [PH_W-1:0] CSH_END = PH_W'(T_CSH - 1);
    localparam logic [PH_W-1:0] RWR_END = PH_W'(T_RWR - 1);

    // LIMIT leaves room for the hold phase so total CS-low time stays within tCSM
    localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(T_CSM_CYCLES - T_CSH - 1);
    localparam logic [CNT_WIDTH-1:0] WARN_AT = CNT_WIDTH'(T_CSM_CYCLES - T_CSH - 1 - T_CSM_MARGIN);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        ACTIVE   = 3'd2,
        HOLD     = 3'd3,
        RECOVERY = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [CNT_WIDTH-1:0]   tcsm_q, tcsm_d;
    logic [NR_CS-1:0]       sel_q, sel_d;
    logic [NR_CS-1:0]       cs_n_q, cs_n_d;
    logic                   viol_q, viol_d;
    logic                   err_q, err_d;
    logic                   sel_onehot;
    logic                   cs_low_d;

    assign sel_onehot = (cs_sel_i != '0) && ((cs_sel_i & (cs_sel_i - NR_CS'(1))) == '0);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + PH_W'(1);
        tcsm_d  = tcsm_q;
        sel_d   = sel_q;
        viol_d  = 1'b0;
        err_d   = err_q;

        if (err_clr_i) begin
            err_d = 1'b0;
        end

        if ((state_q == SETUP || state_q == ACTIVE) && tcsm_q != '1) begin
            tcsm_d = tcsm_q + CNT_WIDTH'(1);
        end

        unique case (state_q)
            IDLE: begin
                phase_d = '0;
                if (req_i) begin
                    if (sel_onehot) begin
                        state_d = SETUP;
                        sel_d   = cs_sel_i;
                        tcsm_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (!req_i) begin
                    state_d = HOLD;
                    phase_d = '0;
                end else if (phase_q == CSS_END) begin
                    state_d = ACTIVE;
                    phase_d = '0;
                end
            end
            ACTIVE: begin
                phase_d = '0;
                if (tcsm_q >= LIMIT) begin
                    state_d = HOLD;
                    viol_d  = 1'b1;
                end else if (!req_i) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (phase_q == CSH_END) begin
                    state_d = RECOVERY;
                    phase_d = '0;
                end
            end
            RECOVERY: begin
                if (phase_q == RWR_END) begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    assign cs_low_d = (state_d == SETUP) || (state_d == ACTIVE) || (state_d == HOLD);
    assign cs_n_d   = ~(sel_d & {NR_CS{cs_low_d}});

    always_ff @(posedge clk270 or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            phase_q <= '0;
            tcsm_q  <= '0;
            sel_q   <= '0;
            cs_n_q  <= '1;
            viol_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            tcsm_q  <= tcsm_d;
            sel_q   <= sel_d;
            cs_n_q  <= cs_n_d;
            viol_q  <= viol_d;
            err_q   <= err_d;
        end
    end

    assign ready_o     = (state_q == IDLE);
    assign ck_en_o     = (state_q == ACTIVE);
    assign tcsm_warn_o = (state_q == ACTIVE) && (tcsm_q >= WARN_AT);
    assign tcsm_viol_o = viol_q;
    assign sel_err_o   = err_q;
    assign hyper_cs_no = cs_n_q;

endmodule

// File: tb/tb_hyperbus_cs_ctrl.sv
// tb/tb_hyperbus_cs_ctrl.sv - scoreboard bench for hyperbus_cs_ctrl
module tb_hyperbus_cs_ctrl;

    typedef struct packed {
        logic [3:0] cs;
        logic       ck;
        logic       rdy;
        logic       warn;
        logic       viol;
        logic       err;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    obs_t sb[$];

    // default instance
    logic       req_a = 0, clr_a = 0;
    logic [1:0] sel_a = '0;
    logic       rdy_a, ck_a, warn_a, viol_a, err_a;
    logic [1:0] cs_a;

    // short tCSM instance
    logic       req_b = 0, clr_b = 0;
    logic [1:0] sel_b = '0;
    logic       rdy_b, ck_b, warn_b, viol_b, err_b;
    logic [1:0] cs_b;

    // four-device instance
    logic       req_c = 0, clr_c = 0;
    logic [3:0] sel_c = '0;
    logic       rdy_c, ck_c, warn_c, viol_c, err_c;
    logic [3:0] cs_c;

    hyperbus_cs_ctrl dut_a (
        .clk270(clk), .rst_ni(rst_n), .req_i(req_a), .cs_sel_i(sel_a),
        .ready_o(rdy_a), .ck_en_o(ck_a), .hyper_cs_no(cs_a),
        .tcsm_warn_o(warn_a), .tcsm_viol_o(viol_a), .sel_err_o(err_a), .err_clr_i(clr_a)
    );

    hyperbus_cs_ctrl #(.T_CSM_CYCLES(20), .T_CSM_MARGIN(4)) dut_b (
        .clk270(clk), .rst_ni(rst_n), .req_i(req_b), .cs_sel_i(sel_b),
        .ready_o(rdy_b), .ck_en_o(ck_b), .hyper_cs_no(cs_b),
        .tcsm_warn_o(warn_b), .tcsm_viol_o(viol_b), .sel_err_o(err_b), .err_clr_i(clr_b)
    );

    hyperbus_cs_ctrl #(.NR_CS(4)) dut_c (
        .clk270(clk), .rst_ni(rst_n), .req_i(req_c), .cs_sel_i(sel_c),
        .ready_o(rdy_c), .ck_en_o(ck_c), .hyper_cs_no(cs_c),
        .tcsm_warn_o(warn_c), .tcsm_viol_o(viol_c), .sel_err_o(err_c), .err_clr_i(clr_c)
    );

    function automatic obs_t mk(logic [3:0] cs, logic ck, logic rdy, logic warn, logic viol, logic err);
        obs_t o;
        o = '{cs: cs, ck: ck, rdy: rdy, warn: warn, viol: viol, err: err};
        return o;
    endfunction

    function automatic obs_t obs_a();
        return mk({2'b11, cs_a}, ck_a, rdy_a, warn_a, viol_a, err_a);
    endfunction

    function automatic obs_t obs_b();
        return mk({2'b11, cs_b}, ck_b, rdy_b, warn_b, viol_b, err_b);
    endfunction

    function automatic obs_t obs_c();
        return mk(cs_c, ck_c, rdy_c, warn_c, viol_c, err_c);
    endfunction

    task automatic test_reset();
        obs_t want, got;
        #12;
        want = mk(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        got = obs_a();
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL reset_a: got cs/ck/rdy/warn/viol/err=%b want %b", got, want);
        end
        got = obs_b();
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL reset_b: got cs/ck/rdy/warn/viol/err=%b want %b", got, want);
        end
        got = obs_c();
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL reset_c: got cs/ck/rdy/warn/viol/err=%b want %b", got, want);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        obs_t want, got;
        for (int i = 0; i < 20; i++) begin
            req_a = (i <= 10);
            sel_a = 2'b01;
            want = mk({2'b11, (i <= 11) ? 2'b10 : 2'b11}, (i >= 1 && i <= 10), (i >= 18), 1'b0, 1'b0, 1'b0);
            sb.push_back(want);
            @(posedge clk);
            #1;
            want = sb.pop_front();
            got = obs_a();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL basic cyc %0d: got cs/ck/rdy/warn/viol/err=%b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_tcsm_back_to_back();
        obs_t want, got;
        logic low;
        for (int i = 0; i < 38; i++) begin
            req_b = (i <= 28);
            sel_b = 2'b01;
            low = (i <= 19) || (i >= 27 && i <= 29);
            want = mk({2'b11, low ? 2'b10 : 2'b11}, (i >= 1 && i <= 18) || (i == 28),
                      (i == 26) || (i >= 36), (i >= 14 && i <= 18), (i == 19), 1'b0);
            sb.push_back(want);
            @(posedge clk);
            #1;
            want = sb.pop_front();
            got = obs_b();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL tcsm cyc %0d: got cs/ck/rdy/warn/viol/err=%b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_sel_err();
        obs_t want, got;
        logic [1:0] sels [6] = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
        logic       reqs [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       clrs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       errs [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            req_a = reqs[i];
            sel_a = sels[i];
            clr_a = clrs[i];
            sb.push_back(mk(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, errs[i]));
            @(posedge clk);
            #1;
            want = sb.pop_front();
            got = obs_a();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL sel_err step %0d: got cs/ck/rdy/warn/viol/err=%b want %b", i, got, want);
            end
        end
        clr_a = 1'b0;
    endtask

    task automatic test_abort();
        obs_t want, got;
        for (int i = 0; i < 10; i++) begin
            req_a = (i == 0);
            sel_a = 2'b10;
            want = mk({2'b11, (i <= 1) ? 2'b01 : 2'b11}, 1'b0, (i >= 8), 1'b0, 1'b0, 1'b0);
            sb.push_back(want);
            @(posedge clk);
            #1;
            want = sb.pop_front();
            got = obs_a();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL abort cyc %0d: got cs/ck/rdy/warn/viol/err=%b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t want, got;
        for (int i = 0; i < 4; i++) begin
            req_a = 1'b1;
            sel_a = 2'b01;
            sb.push_back(mk(4'b1110, (i >= 1), 1'b0, 1'b0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            want = sb.pop_front();
            got = obs_a();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL areset_pre cyc %0d: got cs/ck/rdy/warn/viol/err=%b want %b", i, got, want);
            end
        end
        #2;
        rst_n = 1'b0;
        req_a = 1'b0;
        #1;
        want = mk(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        got = obs_a();
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL areset_now: got cs/ck/rdy/warn/viol/err=%b want %b", got, want);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got = obs_a();
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL areset_release: got cs/ck/rdy/warn/viol/err=%b want %b", got, want);
        end
    endtask

    task automatic test_nr_cs4();
        obs_t want, got;
        for (int i = 0; i < 14; i++) begin
            req_c = (i <= 5);
            sel_c = (i == 0) ? 4'b0100 : 4'b0001;
            want = mk((i <= 6) ? 4'b1011 : 4'b1111, (i >= 1 && i <= 5), (i >= 13), 1'b0, 1'b0, 1'b0);
            sb.push_back(want);
            @(posedge clk);
            #1;
            want = sb.pop_front();
            got = obs_c();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL nr_cs4 cyc %0d: got cs/ck/rdy/warn/viol/err=%b want %b", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tcsm_back_to_back();
        test_sel_err();
        test_abort();
        test_async_reset();
        test_nr_cs4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
